// File: rtl/if_stage_if.sv
// Fetch-stage bus: decode handshake, redirect request, instruction memory port
// and the IF/ID register contents presented to decode.
interface if_stage_if;
  localparam int unsigned XLEN = 32;

  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            if_valid;
  logic            if_misalign;
  logic            halted;

  // Fetch stage side
  modport master (
    input  id_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  imem_data,
    output imem_addr,
    output if_pc,
    output if_inst,
    output if_valid,
    output if_misalign,
    output halted
  );

  // Decode / memory / control side
  modport slave (
    output id_ready,
    output redirect_valid,
    output redirect_pc,
    output imem_data,
    input  imem_addr,
    input  if_pc,
    input  if_inst,
    input  if_valid,
    input  if_misalign,
    input  halted
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a BOOT/RUN/HALT
// control FSM with redirect, stall and halt-on-ebreak handling.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;
  logic            misalign_q, misalign_d;
  logic            advance;

  // IF/ID register may be refilled when empty or when decode takes it
  assign advance = (state_q == RUN) && (!if_valid_q || bus.id_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;

    if (bus.redirect_valid) begin
      // Redirect wins over everything and discards any pending instruction
      state_d    = RUN;
      pc_d       = bus.redirect_pc;
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
      misalign_d = (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (advance) begin
            if_pc_d    = pc_q;
            if_inst_d  = bus.imem_data;
            if_valid_d = 1'b1;
            pc_d       = pc_q + XLEN'(4);
            if (bus.imem_data == HALT_INST) state_d = HALT;
          end
        end
        HALT: begin
          // Let decode drain the halting instruction, then show a bubble
          if (if_valid_q && bus.id_ready) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_inst     = if_inst_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_misalign = misalign_q;
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for the main fetch sequence plus
// hand-written halt and reset-during-halt sequences.
module tb_if_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HLT  = 32'h0010_0073;

  logic clk;
  logic rst;
  logic [31:0] mem [0:31];
  int checks;
  int errors;

  if_stage_if bus();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory aliases every 128 bytes
  assign bus.imem_data = mem[bus.imem_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        idr;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eaddr;
    logic        ehalt;
    logic        emis;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic idr, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                              input logic [31:0] eaddr, input logic ehalt, input logic emis);
    vec_t v;
    v.idr = idr; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
    v.einst = einst; v.eaddr = eaddr; v.ehalt = ehalt; v.emis = emis;
    return v;
  endfunction

  function automatic logic [31:0] w(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".if_valid"},    32'(bus.if_valid),    32'(v.ev));
    check({tag, ".if_pc"},       bus.if_pc,            v.epc);
    check({tag, ".if_inst"},     bus.if_inst,          v.einst);
    check({tag, ".imem_addr"},   bus.imem_addr,        v.eaddr);
    check({tag, ".halted"},      32'(bus.halted),      32'(v.ehalt));
    check({tag, ".if_misalign"}, 32'(bus.if_misalign), 32'(v.emis));
  endtask

  // Drive at a falling edge, let one rising edge pass, check at the next falling edge
  task automatic step(input string tag, input vec_t v);
    bus.id_ready       = v.idr;
    bus.redirect_valid = v.rv;
    bus.redirect_pc    = v.rpc;
    @(negedge clk);
    check_outputs(tag, v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 32; k++) mem[k] = w(k);

    //                idr  rv   rpc           ev   if_pc         if_inst  imem_addr     hlt  mis
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        NOP,     32'h0,        1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        w(0),    32'h4,        1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        w(1),    32'h8,        1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        w(1),    32'h8,        1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        w(1),    32'h8,        1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        w(1),    32'h8,        1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        w(2),    32'hC,        1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h40,       1'b0, 32'h8,        NOP,     32'h40,       1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       w(16),   32'h44,       1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h8,        1'b0, 32'h40,       NOP,     32'h8,        1'b0, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        w(2),    32'hC,        1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        w(3),    32'h10,       1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 32'h6,        1'b0, 32'hC,        NOP,     32'h6,        1'b0, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h6,        w(1),    32'hA,        1'b0, 1'b1);
    vecs[14] = mk(1'b1, 1'b1, 32'h8,        1'b0, 32'h6,        NOP,     32'h8,        1'b0, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h6,       NOP,     32'hFFFF_FFFC, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, w(31),  32'h0,        1'b0, 1'b0);

    rst                = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    check_outputs("reset", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b0));
    rst = 1'b1;

    for (int i = 0; i < 17; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Halt on ebreak at 0xC, drain, then resume via redirect
    mem[3] = HLT;
    step("halt_redir", mk(1'b1, 1'b1, 32'h8, 1'b0, 32'hFFFF_FFFC, NOP, 32'h8, 1'b0, 1'b0));
    step("halt_f8",    mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h8, w(2), 32'hC,  1'b0, 1'b0));
    step("halt_fC",    mk(1'b1, 1'b0, 32'h0, 1'b1, 32'hC, HLT,  32'h10, 1'b1, 1'b0));
    step("halt_hold",  mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hC, HLT,  32'h10, 1'b1, 1'b0));
    step("halt_drain", mk(1'b1, 1'b0, 32'h0, 1'b0, 32'hC, NOP,  32'h10, 1'b1, 1'b0));
    step("halt_idle",  mk(1'b1, 1'b0, 32'h0, 1'b0, 32'hC, NOP,  32'h10, 1'b1, 1'b0));
    step("halt_exit",  mk(1'b1, 1'b1, 32'h0, 1'b0, 32'hC, NOP,  32'h0,  1'b0, 1'b0));
    step("halt_res",   mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, w(0), 32'h4,  1'b0, 1'b0));

    // Misaligned redirect into the halting word, then asynchronous reset while halted
    step("rh_redir", mk(1'b1, 1'b1, 32'hE, 1'b0, 32'h0, NOP, 32'hE,  1'b0, 1'b1));
    step("rh_fE",    mk(1'b1, 1'b0, 32'h0, 1'b1, 32'hE, HLT, 32'h12, 1'b1, 1'b1));
    step("rh_hold",  mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hE, HLT, 32'h12, 1'b1, 1'b1));
    bus.id_ready = 1'b1;
    #2 rst = 1'b0;
    #1 check_outputs("rh_async", mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b0));
    @(negedge clk);
    check_outputs("rh_inrst", mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b0));
    mem[3] = w(3);
    rst = 1'b1;
    step("rh_boot", mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP,  32'h0, 1'b0, 1'b0));
    step("rh_f0",   mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, w(0), 32'h4, 1'b0, 1'b0));
    step("rh_f4",   mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h4, w(1), 32'h8, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have parameter HALT_INST, default 32'h0010_0073 (ebreak), instruction that halts fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 id_ready  input  1  decode stage accepts the IF/ID register this cycle.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 imem_addr  output  32  byte address to instruction memory; combinational copy of pc register.
REQ-010 imem_data  input  32  little-endian instruction word returned combinationally, same cycle, for imem_addr.
REQ-011 if_pc  output  32  PC of instruction held in IF/ID register.
REQ-012 if_inst  output  32  instruction held in IF/ID register.
REQ-013 if_valid  output  1  IF/ID register holds a real instruction.
REQ-014 if_misalign  output  1  registered flag: last redirect target had redirect_pc[1:0] != 0.
REQ-015 halted  output  1  high while FSM is in HALT.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALT, encoded in 2 bits.
REQ-017 BOOT: held during reset; one cycle after rst deasserts with if_valid=0, no capture; then RUN unconditionally unless redirect_valid (redirect applies, next state RUN).
REQ-018 "advance" SHALL mean state==RUN and (if_valid==0 or id_ready==1).
REQ-019 On advance without redirect: if_pc<=pc, if_inst<=imem_data, if_valid<=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-020 When not advancing and no redirect: pc, if_pc, if_inst, if_valid SHALL hold (stall).
REQ-021 redirect_valid SHALL take priority over stall, advance, BOOT and HALT: pc<=redirect_pc, if_valid<=0, if_inst<=NOP_INST, state<=RUN.
REQ-022 Redirect SHALL flush the IF/ID register even when if_valid=1 and id_ready=0; the flushed instruction is lost.
REQ-023 if_misalign SHALL load redirect_pc[1:0]!=0 on every redirect and hold otherwise; misaligned PC still drives imem_addr unchanged.
REQ-024 On advance capturing imem_data==HALT_INST: instruction is delivered (if_valid=1), pc<=pc+4, state<=HALT.
REQ-025 HALT: no capture, pc held; if_valid clears when id_ready=1 consumes the pending instruction, if_inst then NOP_INST; exit only by redirect.
REQ-026 halted SHALL equal (state==HALT) combinationally.
REQ-027 imem_addr SHALL always equal pc, including during stall and HALT.
REQ-028 Throughput: one instruction per cycle with id_ready held high; fetch-to-if_valid latency one cycle.

Reset
REQ-029 On rst low (asynchronous): pc=RESET_PC, state=BOOT, if_pc=0, if_inst=NOP_INST, if_valid=0, if_misalign=0.
REQ-030 rst asserted mid-stall or mid-HALT SHALL discard all state immediately; no instruction delivered during reset.
REQ-031 Reset release SHALL be sampled synchronously; first capture occurs on the second rising edge after release.

Verification
REQ-032 Reset release, id_ready=1, memory words W0..W3 at 0,4,8,12 -> if_valid=0 one cycle, then if_pc 0,4,8,12 with if_inst W0..W3 on consecutive cycles.
REQ-033 Stall: id_ready=0 for 3 cycles while if_pc=4 valid -> if_pc=4, if_inst=W1, imem_addr=8 held; release -> if_pc=8 next cycle.
REQ-034 Redirect with id_ready=0 and valid instruction at if_pc=8, redirect_pc=32'h0000_0040 -> next cycle if_valid=0, if_inst=32'h0000_0013, imem_addr=0x40; following cycle if_pc=0x40.
REQ-035 Fetch 32'h0010_0073 at pc=0xC -> delivered with if_pc=0xC, halted=1, imem_addr stays 0x10, if_valid drops after consumption; redirect to 0x0 -> halted=0, fetch resumes at 0.
REQ-036 Redirect to 32'h0000_0006 -> if_misalign=1, imem_addr=6; later redirect to 0x8 -> if_misalign=0. Redirect to 32'hFFFF_FFFC then advance -> imem_addr wraps to 0.
